mem_write_guard: RTL

Parametrised successor to the 4-bit memory write monitor in the user project area. Checks every bus write request against a runtime-programmable region table with per-module permission masks. Forwards granted writes to memory and denies the rest. Denied writes raise a sticky alert, count toward per-module lockout, and are recorded in a violation-log FIFO. Sits between the user-area write initiators and the memory/peripheral write port, with status routed to mprj_io / logic analyzer.

---
 rtl/mem_write_guard_if.sv | 28 ++
 rtl/mem_write_guard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_guard_if.sv
// Write-request / memory-port bundle for mem_write_guard.
// The initiator side drives the request fields. The guard drives the handshake
// ready, the granted-write port and the deny pulse.
interface mem_write_guard_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2
);
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic [ID_W-1:0]   wr_id_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              deny_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_id_i,
        input  wr_ready_o, mem_we_o, mem_addr_o, mem_data_o, deny_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_id_i,
        output wr_ready_o, mem_we_o, mem_addr_o, mem_data_o, deny_o
    );
endinterface

// File: rtl/mem_write_guard.sv
// mem_write_guard: checks each bus write against a programmable region table
// and per-ID permission masks. Granted writes go to memory. Denied writes raise
// a sticky alert, count toward a per-ID lockout and are logged in a FIFO.
// A request is accepted at edge N and decided at edge N+1.
module mem_write_guard #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ID_W        = 2,
    parameter int NUM_REGIONS = 4,
    parameter int LOG_DEPTH   = 4,
    parameter int LOCK_THRESH = 3,
    parameter int CNT_W       = 8,
    localparam int NID        = 2 ** ID_W,
    localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    mem_write_guard_if.slave   bus,
    input  logic               cfg_we_i,
    input  logic [IDX_W-1:0]   cfg_idx_i,
    input  logic               cfg_en_i,
    input  logic [ADDR_W-1:0]  cfg_base_i,
    input  logic [ADDR_W-1:0]  cfg_limit_i,
    input  logic [NID-1:0]     cfg_perm_i,
    input  logic               alert_clr_i,
    input  logic [NID-1:0]     unlock_i,
    output logic               alert_o,
    output logic [CNT_W-1:0]   viol_cnt_o,
    output logic [NID-1:0]     locked_o,
    output logic               log_valid_o,
    input  logic               log_ready_i,
    output logic [ADDR_W-1:0]  log_addr_o,
    output logic [DATA_W-1:0]  log_data_o,
    output logic [ID_W-1:0]    log_id_o,
    output logic               log_overflow_o
);
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W + ID_W;
    localparam logic [3:0] THRESH = 4'(LOCK_THRESH);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(LOG_DEPTH);

    // Region table
    logic [NUM_REGIONS-1:0] en_q, en_d;
    logic [ADDR_W-1:0]      base_q  [NUM_REGIONS];
    logic [ADDR_W-1:0]      base_d  [NUM_REGIONS];
    logic [ADDR_W-1:0]      limit_q [NUM_REGIONS];
    logic [ADDR_W-1:0]      limit_d [NUM_REGIONS];
    logic [NID-1:0]         perm_q  [NUM_REGIONS];
    logic [NID-1:0]         perm_d  [NUM_REGIONS];

    // Registered request awaiting its decision
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [ID_W-1:0]   req_id_q, req_id_d;

    // Decision outputs and status
    logic              mem_we_q, mem_we_d;
    logic              deny_q, deny_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              alert_q, alert_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Violation log FIFO
    logic [ENT_W-1:0]  fifo_mem [LOG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic                   accept;
    logic [NUM_REGIONS-1:0] match_vec;
    logic                   hit;
    logic [NID-1:0]         hit_perm;
    logic                   grant;
    logic                   deny;
    logic                   pop;
    logic                   push_ok;
    logic [NID-1:0]         locked_vec;

    // Ready is held low in reset so nothing is accepted while the table clears
    assign bus.wr_ready_o = ~cfg_we_i & ~wb_rst_i;
    assign accept         = bus.wr_valid_i & bus.wr_ready_o;

    // Per-region address match against the registered request
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        assign match_vec[gi] = en_q[gi] && (base_q[gi] <= req_addr_q) && (req_addr_q <= limit_q[gi]);
    end

    // Table update: config write lands on the next edge
    always_comb begin
        en_d    = en_q;
        base_d  = base_q;
        limit_d = limit_q;
        perm_d  = perm_q;
        if (cfg_we_i) begin
            en_d[cfg_idx_i]    = cfg_en_i;
            base_d[cfg_idx_i]  = cfg_base_i;
            limit_d[cfg_idx_i] = cfg_limit_i;
            perm_d[cfg_idx_i]  = cfg_perm_i;
        end
    end

    // Table registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '0;
                perm_q[i]  <= '0;
            end
        end else begin
            en_q    <= en_d;
            base_q  <= base_d;
            limit_q <= limit_d;
            perm_q  <= perm_d;
        end
    end

    // Decision: lowest-index matching region decides, no match denies
    always_comb begin
        hit      = 1'b0;
        hit_perm = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit      = 1'b1;
                hit_perm = perm_q[i];
            end
        end
        grant = req_valid_q && hit && hit_perm[req_id_q] && !locked_vec[req_id_q];
        deny  = req_valid_q && !grant;
    end

    // Request capture, decision pulses, counters and sticky flags
    always_comb begin
        req_valid_d = accept;
        req_addr_d  = accept ? bus.wr_addr_i : req_addr_q;
        req_data_d  = accept ? bus.wr_data_i : req_data_q;
        req_id_d    = accept ? bus.wr_id_i   : req_id_q;
        mem_we_d    = grant;
        deny_d      = deny;
        mem_addr_d  = grant ? req_addr_q : mem_addr_q;
        mem_data_d  = grant ? req_data_q : mem_data_q;
        cnt_d       = (deny && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        // A new violation wins over a clear in the same cycle
        alert_d     = deny | (alert_q & ~alert_clr_i);
        ovf_d       = (deny && (count_q == FIFO_FULL) && !pop) | (ovf_q & ~alert_clr_i);
    end

    // FIFO bookkeeping: a push into a full FIFO survives only alongside a pop
    always_comb begin
        pop      = log_valid_o && log_ready_i;
        push_ok  = deny && ((count_q != FIFO_FULL) || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_id_q    <= '0;
            mem_we_q    <= 1'b0;
            deny_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            alert_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_id_q    <= req_id_d;
            mem_we_q    <= mem_we_d;
            deny_q      <= deny_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            alert_q     <= alert_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Log storage; occupancy is tracked by the pointers, so no reset needed
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= {req_addr_q, req_data_q, req_id_q};
        end
    end

    // Per-ID strike counter and lockout; unlock clears before a new deny counts
    for (genvar gi = 0; gi < NID; gi++) begin : g_id
        logic [3:0] strike_q, strike_d, strike_base;
        logic       lock_q, lock_d, lock_base;
        logic       deny_here;

        // Next strike/lock state for this ID
        always_comb begin
            deny_here   = deny && (req_id_q == ID_W'(gi));
            strike_base = unlock_i[gi] ? 4'd0 : strike_q;
            lock_base   = unlock_i[gi] ? 1'b0 : lock_q;
            strike_d    = strike_base;
            lock_d      = lock_base;
            if (deny_here) begin
                if (strike_base != 4'hF) begin
                    strike_d = strike_base + 4'd1;
                end
                if (strike_d == THRESH) begin
                    lock_d = 1'b1;
                end
            end
        end

        // Strike/lock registers for this ID
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                strike_q <= 4'd0;
                lock_q   <= 1'b0;
            end else begin
                strike_q <= strike_d;
                lock_q   <= lock_d;
            end
        end

        assign locked_vec[gi] = lock_q;
    end

    assign bus.mem_we_o   = mem_we_q;
    assign bus.deny_o     = deny_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;
    assign alert_o        = alert_q;
    assign log_overflow_o = ovf_q;
    assign viol_cnt_o     = cnt_q;
    assign locked_o       = locked_vec;
    assign log_valid_o    = (count_q != '0);
    // Head is forced to zero when empty so stale entries never show
    assign {log_addr_o, log_data_o, log_id_o} = log_valid_o ? fifo_mem[rd_ptr_q] : '0;
endmodule
